ex_mem_stage_reg: RTL and testbench

//  Parametrised EX->MEM pipeline stage register with valid/ready handshake, 2-entry skid

---
 rtl/ex_mem_stage_reg.sv | 182 ++++++++++++++++++
 tb/tb_ex_mem_stage_reg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX->MEM pipeline stage register with valid/ready handshake.
// Storage is a main entry, which drives the outputs, plus one skid entry.
// The skid entry absorbs the single in-flight entry when downstream stalls.
// in_ready is a decode of a flop, so it never sees out_ready combinationally.
// A synchronous flush drops everything held. A saturating counter records stalled edges.
// CAPTURE_NEG selects which clock edge updates all state.
module ex_mem_stage_reg #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int RADDR_W     = 4,
    parameter int CNT_W       = 16,
    parameter bit CAPTURE_NEG = 1'b1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  data_val_in,
    input  logic [DATA_W-1:0]  result_in,
    input  logic [ADDR_W-1:0]  addr_in,
    input  logic [RADDR_W-1:0] c_addr_in,
    input  logic               reg_write_in,
    input  logic               data_read_in,
    input  logic               data_write_in,
    input  logic               reg_addr_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  data_val,
    output logic [DATA_W-1:0]  result,
    output logic [ADDR_W-1:0]  addr,
    output logic [RADDR_W-1:0] c_addr,
    output logic               reg_write,
    output logic               data_read,
    output logic               data_write,
    output logic               reg_addr,
    output logic [CNT_W-1:0]   stall_count
);

    typedef struct packed {
        logic [DATA_W-1:0]  data_val;
        logic [DATA_W-1:0]  result;
        logic [ADDR_W-1:0]  addr;
        logic [RADDR_W-1:0] c_addr;
        logic               reg_write;
        logic               data_read;
        logic               data_write;
        logic               reg_addr;
    } entry_t;

    // Bit 0 is main_valid and bit 1 is skid_valid.
    // The valid flags therefore read straight off the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state, state_next;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           entry_in;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             main_valid, skid_valid;
    logic             acc, pop;

    assign main_valid = state[0];
    assign skid_valid = state[1];
    assign in_ready   = ~skid_valid;
    assign out_valid  = main_valid;
    assign acc        = in_valid & in_ready;
    assign pop        = main_valid & out_ready;

    assign entry_in = '{
        data_val:   data_val_in,
        result:     result_in,
        addr:       addr_in,
        c_addr:     c_addr_in,
        reg_write:  reg_write_in,
        data_read:  data_read_in,
        data_write: data_write_in,
        reg_addr:   reg_addr_in
    };

    // Next-state, payload transfers and the stall counter.
    always_comb begin
        // NOTE: every variable gets a hold default first, so no path through the
        // branches below can leave one unassigned and infer a latch.
        state_next = state;
        main_d     = main_q;
        skid_d     = skid_q;
        stall_d    = stall_q;

        if (flush) begin
            // Payload regs keep stale data. Only the valid flags are dropped.
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        main_d     = entry_in;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        main_d = entry_in;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end else if (acc) begin
                        skid_d     = entry_in;
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d     = skid_q;
                        state_next = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end

        // The stall counter ignores flush and sticks at all-ones.
        if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State register clocked on the edge chosen by CAPTURE_NEG, with async reset on both variants.
    generate
        if (CAPTURE_NEG) begin : g_neg
            // Falling-edge state register.
            always_ff @(negedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    // NOTE: the payload regs are reset too, not just the valid flags.
                    // Outputs must read zero straight out of reset.
                    state   <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                    stall_q <= '0;
                end else begin
                    // NOTE: sequential state uses non-blocking assignments only.
                    // Every flop then samples pre-edge values.
                    state   <= state_next;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                    stall_q <= stall_d;
                end
            end
        end else begin : g_pos
            // Rising-edge state register.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    state   <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                    stall_q <= '0;
                end else begin
                    state   <= state_next;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                    stall_q <= stall_d;
                end
            end
        end
    endgenerate

    // Data fields show the main payload unconditionally.
    // Side-effecting control bits are gated by out_valid, so bubbles do nothing.
    assign data_val    = main_q.data_val;
    assign result      = main_q.result;
    assign addr        = main_q.addr;
    assign c_addr      = main_q.c_addr;
    assign reg_addr    = main_q.reg_addr;
    assign reg_write   = main_q.reg_write  & main_valid;
    assign data_read   = main_q.data_read  & main_valid;
    assign data_write  = main_q.data_write & main_valid;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb_ex_mem_stage_reg: directed vectors for the EX->MEM stage register.
// Three instances share one input set:
//   n_ : falling-edge capture, CNT_W = 16
//   p_ : rising-edge capture
//   s_ : falling-edge capture, CNT_W = 4
// Inputs change just after each falling edge.
// The rising-edge copy therefore sees every vector half a cycle before the falling-edge copies.
module tb_ex_mem_stage_reg;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        flush, in_valid, out_ready;
    logic [15:0] data_val_in, result_in;
    logic [7:0]  addr_in;
    logic [3:0]  c_addr_in;
    logic        reg_write_in, data_read_in, data_write_in, reg_addr_in;

    logic        n_in_ready, n_out_valid, n_reg_write, n_data_read, n_data_write, n_reg_addr;
    logic [15:0] n_data_val, n_result, n_stall;
    logic [7:0]  n_addr;
    logic [3:0]  n_c_addr;

    logic        p_in_ready, p_out_valid, p_reg_write, p_data_read, p_data_write, p_reg_addr;
    logic [15:0] p_data_val, p_result, p_stall;
    logic [7:0]  p_addr;
    logic [3:0]  p_c_addr;

    logic        s_in_ready, s_out_valid, s_reg_write, s_data_read, s_data_write, s_reg_addr;
    logic [15:0] s_data_val, s_result;
    logic [7:0]  s_addr;
    logic [3:0]  s_c_addr;
    logic [3:0]  s_stall;

    ex_mem_stage_reg #(.CAPTURE_NEG(1'b1)) dut_neg (
        .CLK(CLK), .RST_N(RST_N), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .data_val_in(data_val_in), .result_in(result_in), .addr_in(addr_in), .c_addr_in(c_addr_in),
        .reg_write_in(reg_write_in), .data_read_in(data_read_in), .data_write_in(data_write_in),
        .reg_addr_in(reg_addr_in), .out_valid(n_out_valid), .out_ready(out_ready),
        .data_val(n_data_val), .result(n_result), .addr(n_addr), .c_addr(n_c_addr),
        .reg_write(n_reg_write), .data_read(n_data_read), .data_write(n_data_write),
        .reg_addr(n_reg_addr), .stall_count(n_stall)
    );

    ex_mem_stage_reg #(.CAPTURE_NEG(1'b0)) dut_pos (
        .CLK(CLK), .RST_N(RST_N), .flush(flush), .in_valid(in_valid), .in_ready(p_in_ready),
        .data_val_in(data_val_in), .result_in(result_in), .addr_in(addr_in), .c_addr_in(c_addr_in),
        .reg_write_in(reg_write_in), .data_read_in(data_read_in), .data_write_in(data_write_in),
        .reg_addr_in(reg_addr_in), .out_valid(p_out_valid), .out_ready(out_ready),
        .data_val(p_data_val), .result(p_result), .addr(p_addr), .c_addr(p_c_addr),
        .reg_write(p_reg_write), .data_read(p_data_read), .data_write(p_data_write),
        .reg_addr(p_reg_addr), .stall_count(p_stall)
    );

    ex_mem_stage_reg #(.CNT_W(4), .CAPTURE_NEG(1'b1)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .data_val_in(data_val_in), .result_in(result_in), .addr_in(addr_in), .c_addr_in(c_addr_in),
        .reg_write_in(reg_write_in), .data_read_in(data_read_in), .data_write_in(data_write_in),
        .reg_addr_in(reg_addr_in), .out_valid(s_out_valid), .out_ready(out_ready),
        .data_val(s_data_val), .result(s_result), .addr(s_addr), .c_addr(s_c_addr),
        .reg_write(s_reg_write), .data_read(s_data_read), .data_write(s_data_write),
        .reg_addr(s_reg_addr), .stall_count(s_stall)
    );

    always #5 CLK = ~CLK;

    // Each record holds the inputs plus the outputs expected after the active edge.
    typedef struct {
        logic        iv;
        logic        orr;
        logic        fl;
        logic [15:0] val;
        logic        ev;
        logic        eir;
        logic [15:0] eres;
        logic [15:0] est;
    } vec_t;

    vec_t        vecs[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        pv, pir;
    logic [15:0] pst;

    function automatic vec_t mk(input logic iv, input logic orr, input logic fl,
                                input logic [15:0] val, input logic ev, input logic eir,
                                input logic [15:0] eres, input logic [15:0] est);
        vec_t v;
        v.iv = iv; v.orr = orr; v.fl = fl; v.val = val;
        v.ev = ev; v.eir = eir; v.eres = eres; v.est = est;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every other payload field is encoded from the result value.
    task automatic drive(input vec_t v);
        in_valid      = v.iv;
        out_ready     = v.orr;
        flush         = v.fl;
        result_in     = v.val;
        data_val_in   = v.val ^ 16'h5A5A;
        addr_in       = v.val[7:0] + 8'd1;
        c_addr_in     = v.val[3:0];
        reg_write_in  = 1'b1;
        data_read_in  = ~v.val[0];
        data_write_in = v.val[0];
        reg_addr_in   = v.val[1];
    endtask

    task automatic step_check(input vec_t v, input string tag);
        drive(v);
        @(posedge CLK); #1;
        check({tag, " pos out_valid"}, p_out_valid, v.ev);
        check({tag, " pos in_ready"}, p_in_ready, v.eir);
        check({tag, " pos stall"}, p_stall, v.est);
        if (v.ev) check({tag, " pos result"}, p_result, v.eres);
        check({tag, " neg hold out_valid"}, n_out_valid, pv);
        check({tag, " neg hold in_ready"}, n_in_ready, pir);
        check({tag, " neg hold stall"}, n_stall, pst);
        @(negedge CLK); #1;
        check({tag, " out_valid"}, n_out_valid, v.ev);
        check({tag, " in_ready"}, n_in_ready, v.eir);
        check({tag, " stall"}, n_stall, v.est);
        check({tag, " reg_write"}, n_reg_write, v.ev);
        check({tag, " data_write"}, n_data_write, v.ev & v.eres[0]);
        check({tag, " data_read"}, n_data_read, v.ev & ~v.eres[0]);
        if (v.ev) begin
            check({tag, " result"}, n_result, v.eres);
            check({tag, " data_val"}, n_data_val, v.eres ^ 16'h5A5A);
            check({tag, " addr"}, n_addr, v.eres[7:0] + 8'd1);
            check({tag, " c_addr"}, n_c_addr, v.eres[3:0]);
            check({tag, " reg_addr"}, n_reg_addr, v.eres[1]);
        end
        check({tag, " pos hold out_valid"}, p_out_valid, v.ev);
        pv  = v.ev;
        pir = v.eir;
        pst = v.est;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " neg out_valid"}, n_out_valid, 1'b0);
        check({tag, " neg in_ready"}, n_in_ready, 1'b1);
        check({tag, " neg stall"}, n_stall, 16'h0);
        check({tag, " neg result"}, n_result, 16'h0);
        check({tag, " neg reg_write"}, n_reg_write, 1'b0);
        check({tag, " pos out_valid"}, p_out_valid, 1'b0);
        check({tag, " pos in_ready"}, p_in_ready, 1'b1);
        check({tag, " pos stall"}, p_stall, 16'h0);
        check({tag, " sat stall"}, s_stall, 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        idle  = mk(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 16'h0);
        RST_N = 1'b0;
        drive(idle);
        #3;
        check_reset("reset");
        #9 RST_N = 1'b1;
        @(negedge CLK); #1;
        pv = 1'b0; pir = 1'b1; pst = 16'h0;

        // Stream: results 1..4 with out_ready high.
        vecs.push_back(mk(1, 1, 0, 16'h0001, 1, 1, 16'h0001, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0002, 1, 1, 16'h0002, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0003, 1, 1, 16'h0003, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0004, 1, 1, 16'h0004, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 0));
        // Backpressure: A and B fill the stage, C is held off, then drained in order.
        vecs.push_back(mk(1, 0, 0, 16'h00AA, 1, 1, 16'h00AA, 0));
        vecs.push_back(mk(1, 0, 0, 16'h00BB, 1, 0, 16'h00AA, 1));
        vecs.push_back(mk(1, 0, 0, 16'h00CC, 1, 0, 16'h00AA, 2));
        vecs.push_back(mk(1, 0, 0, 16'h00CC, 1, 0, 16'h00AA, 3));
        vecs.push_back(mk(1, 1, 0, 16'h00CC, 1, 1, 16'h00BB, 3));
        vecs.push_back(mk(1, 1, 0, 16'h00CC, 1, 1, 16'h00CC, 3));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 3));
        // Flush while FULL with an incoming entry; the stall on the flush edge still counts.
        vecs.push_back(mk(1, 0, 0, 16'h0011, 1, 1, 16'h0011, 3));
        vecs.push_back(mk(1, 0, 0, 16'h0012, 1, 0, 16'h0011, 4));
        vecs.push_back(mk(1, 0, 1, 16'h0013, 0, 1, 16'h0000, 5));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 5));
        // Flush while EMPTY discards an accepted entry.
        vecs.push_back(mk(1, 1, 1, 16'h0021, 0, 1, 16'h0000, 5));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 5));
        // Flush in ONE with a concurrent pop and accept.
        vecs.push_back(mk(1, 1, 0, 16'h0033, 1, 1, 16'h0033, 5));
        vecs.push_back(mk(1, 1, 1, 16'h0035, 0, 1, 16'h0000, 5));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 5));

        for (int i = 0; i < vecs.size(); i++) begin
            step_check(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset while FULL, with no clock edge in between.
        step_check(mk(1, 0, 0, 16'h0031, 1, 1, 16'h0031, 5), "rst_fill0");
        step_check(mk(1, 0, 0, 16'h0032, 1, 0, 16'h0031, 6), "rst_fill1");
        out_ready = 1'b1;
        #1;
        check("in_ready indep of out_ready neg", n_in_ready, 1'b0);
        check("in_ready indep of out_ready pos", p_in_ready, 1'b0);
        RST_N = 1'b0;
        #1;
        check_reset("async reset");
        drive(idle);
        @(posedge CLK); #3;
        RST_N = 1'b1;
        @(negedge CLK); #1;
        pv = 1'b0; pir = 1'b1; pst = 16'h0;
        step_check(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 0), "post_reset");

        // Saturation: the 4-bit counter sticks at 15 while the 16-bit one keeps counting.
        step_check(mk(1, 0, 0, 16'h0041, 1, 1, 16'h0041, 0), "sat_load");
        for (int k = 1; k <= 20; k++) begin
            step_check(mk(0, 0, 0, 16'h0000, 1, 1, 16'h0041, 16'(k)), $sformatf("sat%0d", k));
            check($sformatf("sat%0d cnt4", k), s_stall, (k < 15) ? k : 15);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
